// File: rtl/uart_rx_framer_pkg.sv
// Shared constants for the UART receive framer and its payload FIFO.
package uart_rx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    // Error causes reported on err_code
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CSUM     = 3'd1;
    localparam logic [2:0] ERR_LEN      = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_BREAK    = 3'd4;
    localparam logic [2:0] ERR_OVERFLOW = 3'd5;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    // FIFO entry layout: {err, last, data}
    localparam int ENTRY_W    = 10;
    localparam int ENTRY_LAST = 8;
    localparam int ENTRY_ERR  = 9;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic err, input logic last,
                                                      input logic [7:0] data);
        return {err, last, data};
    endfunction

endpackage

// File: rtl/uart_rx_framer_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count output.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    // Accept pop when non-empty; accept push when not full or when a pop frees a slot
    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        do_wr    = wr_en && ((count_q != CW'(DEPTH)) || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/uart_rx_framer.sv
// Packet framer behind uart_rx: SOF, LEN, payload, CSUM. Payload goes out on a
// valid/ready stream, each frame terminated by exactly one last-tagged byte.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int         DEPTH          = 16,
    parameter int         MAX_LEN        = 64,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx_valid,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_break,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_err,
    output logic       frame_good,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   sum_q, sum_d;
    logic         hold_valid_q, hold_valid_d;
    logic [7:0]   hold_data_q, hold_data_d;
    logic         drop_q, drop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic         frame_good_q, frame_good_d;
    logic         frame_err_q, frame_err_d;
    logic [2:0]   err_code_q, err_code_d;
    logic         overflow_q, overflow_d;

    logic               abort;
    logic [2:0]         abort_code;
    logic               fifo_wr_en;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [CW-1:0]      fifo_count;
    logic [7:0]         csum_total;
    logic               csum_fail;

    // Abort detection: break beats an arriving byte, an arriving byte beats timeout
    always_comb begin
        abort      = 1'b0;
        abort_code = ERR_NONE;
        if (state_q != ST_IDLE) begin
            if (uart_rx_break) begin
                abort      = 1'b1;
                abort_code = ERR_BREAK;
            end else if (!uart_rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                abort      = 1'b1;
                abort_code = ERR_TIMEOUT;
            end
        end
    end

    // Frame FSM, checksum, length count, hold register and FIFO push decisions
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        drop_d       = drop_q;
        frame_good_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        overflow_d   = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        csum_total   = sum_q + uart_rx_data;
        csum_fail    = (csum_total != 8'h00) || drop_q;

        if (abort) begin
            // Terminate any partially delivered frame so the consumer sees last=1
            if (hold_valid_q) begin
                fifo_wr_en   = 1'b1;
                fifo_wr_data = pack_entry(1'b1, 1'b1, hold_data_q);
            end
            hold_valid_d = 1'b0;
            frame_err_d  = 1'b1;
            err_code_d   = abort_code;
            state_d      = ST_IDLE;
        end else if (uart_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (uart_rx_data == SOF) begin
                        state_d      = ST_LEN;
                        sum_d        = 8'h00;
                        drop_d       = 1'b0;
                        hold_valid_d = 1'b0;
                    end
                end
                ST_LEN: begin
                    sum_d = uart_rx_data;
                    cnt_d = uart_rx_data;
                    if (uart_rx_data == 8'h00) begin
                        state_d = ST_CSUM;
                    end else if (uart_rx_data > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    sum_d = sum_q + uart_rx_data;
                    // Previous byte is now known not to be last; keep one slot for the terminator
                    if (hold_valid_q) begin
                        if (fifo_count < CW'(DEPTH - 1)) begin
                            fifo_wr_en   = 1'b1;
                            fifo_wr_data = pack_entry(1'b0, 1'b0, hold_data_q);
                        end else begin
                            overflow_d = 1'b1;
                            drop_d     = 1'b1;
                        end
                    end
                    hold_data_d  = uart_rx_data;
                    hold_valid_d = 1'b1;
                    cnt_d        = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (hold_valid_q) begin
                        fifo_wr_en   = 1'b1;
                        fifo_wr_data = pack_entry(csum_fail, 1'b1, hold_data_q);
                    end
                    hold_valid_d = 1'b0;
                    if (csum_fail) begin
                        frame_err_d = 1'b1;
                        err_code_d  = drop_q ? ERR_OVERFLOW : ERR_CSUM;
                    end else begin
                        frame_good_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Inter-byte timer restarts on every byte and idles at zero outside a frame
        if ((state_d == ST_IDLE) || uart_rx_valid) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sum_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            drop_q       <= 1'b0;
            timer_q      <= '0;
            frame_good_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            drop_q       <= drop_d;
            timer_q      <= timer_d;
            frame_good_q <= frame_good_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            overflow_q   <= overflow_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (fifo_wr_en),
        .wr_data  (fifo_wr_data),
        .rd_en    (m_ready),
        .rd_valid (m_valid),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign m_data     = fifo_rd_data[7:0];
    assign m_last     = fifo_rd_data[ENTRY_LAST];
    assign m_err      = fifo_rd_data[ENTRY_ERR];
    assign frame_good = frame_good_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: table of whole frames plus hand-written
// sequences for timeout, overflow, break, max length and mid-frame reset.
module tb_uart_rx_framer;

    logic       clk;
    logic       resetn;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_break;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_err;
    logic       frame_good;
    logic       frame_err;
    logic [2:0] err_code;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Monitor state (written only by the monitor process)
    logic [9:0] got [0:511];
    int got_n = 0;
    int n_good = 0;
    int n_err = 0;
    int n_ovf = 0;

    typedef struct {
        int          nb;    // bytes to send
        logic [63:0] b;     // bytes, first byte in the top octet
        int          nout;  // expected stream entries
        logic [39:0] out;   // expected {err,last,data} entries, first in top 10 bits
        logic        good;  // 1: frame_good expected, 0: frame_err expected
        logic [2:0]  code;  // err_code after the frame
    } vec_t;

    vec_t vecs [0:6];

    uart_rx_framer dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_err         (m_err),
        .frame_good    (frame_good),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample outputs on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (resetn) begin
            if (m_valid && m_ready) begin
                if (got_n < 512) got[got_n] = {m_err, m_last, m_data};
                got_n = got_n + 1;
            end
            if (frame_good) n_good = n_good + 1;
            if (frame_err)  n_err  = n_err + 1;
            if (overflow)   n_ovf  = n_ovf + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic entry_at(input int idx, output logic [9:0] e);
        if (idx >= 0 && idx < 512) e = got[idx];
        else e = 10'h3FF;
    endtask

    initial begin
        int s_got, s_good, s_err, s_ovf;
        logic [9:0] e;

        vecs[0] = '{6, {48'h7E0311223397, 16'h0}, 3, {10'h011, 10'h022, 10'h133, 10'h000}, 1'b1, 3'd0};
        vecs[1] = '{6, {48'h7E0311223300, 16'h0}, 3, {10'h011, 10'h022, 10'h333, 10'h000}, 1'b0, 3'd1};
        vecs[2] = '{2, {16'h7E41, 48'h0},         0, 40'h0,                                  1'b0, 3'd2};
        vecs[3] = '{6, {48'h7E0311223397, 16'h0}, 3, {10'h011, 10'h022, 10'h133, 10'h000}, 1'b1, 3'd2};
        vecs[4] = '{3, {24'h7E0000, 40'h0},       0, 40'h0,                                  1'b1, 3'd2};
        vecs[5] = '{3, {24'h7E0005, 40'h0},       0, 40'h0,                                  1'b0, 3'd1};
        vecs[6] = '{5, {40'h127E015AA5, 24'h0},   1, {10'h15A, 30'h0},                       1'b1, 3'd1};

        resetn        = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        uart_rx_break = 1'b0;
        m_ready       = 1'b1;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(1);

        check("reset_m_valid",    {31'd0, m_valid},    32'd0);
        check("reset_frame_good", {31'd0, frame_good}, 32'd0);
        check("reset_frame_err",  {31'd0, frame_err},  32'd0);
        check("reset_overflow",   {31'd0, overflow},   32'd0);
        check("reset_err_code",   {29'd0, err_code},   32'd0);

        // Table-driven whole frames with the consumer always ready
        for (int v = 0; v < 7; v++) begin
            s_got = got_n; s_good = n_good; s_err = n_err;
            for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[63-8*i -: 8]);
            wait_cycles(8);
            $display("vec %0d: %0d bytes, %0d out, good=%0d err=%0d code=%0d",
                     v, vecs[v].nb, got_n - s_got, n_good - s_good, n_err - s_err, err_code);
            check($sformatf("vec%0d_nout", v), got_n - s_got, vecs[v].nout);
            for (int k = 0; k < vecs[v].nout; k++) begin
                entry_at(s_got + k, e);
                check($sformatf("vec%0d_entry%0d", v, k), {22'd0, e}, {22'd0, vecs[v].out[39-10*k -: 10]});
            end
            check($sformatf("vec%0d_good", v), n_good - s_good, vecs[v].good ? 1 : 0);
            check($sformatf("vec%0d_err", v),  n_err - s_err,   vecs[v].good ? 0 : 1);
            check($sformatf("vec%0d_code", v), {29'd0, err_code}, {29'd0, vecs[v].code});
            check($sformatf("vec%0d_drained", v), {31'd0, m_valid}, 32'd0);
        end

        // Maximum accepted length: 64 bytes 0..63, checksum E0
        s_got = got_n; s_good = n_good;
        send_byte(8'h7E);
        send_byte(8'h40);
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        send_byte(8'hE0);
        wait_cycles(8);
        $display("maxlen: %0d out, good=%0d", got_n - s_got, n_good - s_good);
        check("maxlen_nout", got_n - s_got, 64);
        entry_at(s_got, e);
        check("maxlen_first", {22'd0, e}, 32'h000);
        entry_at(s_got + 63, e);
        check("maxlen_last", {22'd0, e}, 32'h13F);
        check("maxlen_good", n_good - s_good, 1);

        // Timeout in PAYLOAD: AA terminated with err, code 3
        s_got = got_n; s_err = n_err;
        send_byte(8'h7E);
        send_byte(8'h02);
        send_byte(8'hAA);
        wait_cycles(49990);
        check("timeout_not_early", n_err - s_err, 0);
        wait_cycles(30);
        entry_at(s_got, e);
        $display("timeout: %0d out, entry=%0h code=%0d", got_n - s_got, e, err_code);
        check("timeout_nout", got_n - s_got, 1);
        check("timeout_entry", {22'd0, e}, 32'h3AA);
        check("timeout_err", n_err - s_err, 1);
        check("timeout_code", {29'd0, err_code}, 32'd3);

        // Overflow with consumer stalled: LEN=20 bytes 1..20, checksum 1A
        m_ready = 1'b0;
        s_got = got_n; s_err = n_err; s_ovf = n_ovf;
        send_byte(8'h7E);
        send_byte(8'h14);
        for (int i = 1; i <= 20; i++) send_byte(8'(i));
        send_byte(8'h1A);
        wait_cycles(4);
        $display("overflow: ovf=%0d err=%0d code=%0d", n_ovf - s_ovf, n_err - s_err, err_code);
        check("ovf_pulses", n_ovf - s_ovf, 4);
        check("ovf_err", n_err - s_err, 1);
        check("ovf_code", {29'd0, err_code}, 32'd5);
        check("ovf_held_data", {24'd0, m_data}, 32'h01);
        m_ready = 1'b1;
        wait_cycles(25);
        check("ovf_nout", got_n - s_got, 16);
        for (int i = 0; i < 15; i++) begin
            entry_at(s_got + i, e);
            check($sformatf("ovf_entry%0d", i), {22'd0, e}, 32'(i + 1));
        end
        entry_at(s_got + 15, e);
        check("ovf_terminator", {22'd0, e}, 32'h314);

        // Break coinciding with a byte after two payload bytes
        s_got = got_n; s_err = n_err;
        send_byte(8'h7E);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h03;
        uart_rx_break = 1'b1;
        wait_cycles(1);
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        wait_cycles(8);
        $display("break: %0d out, code=%0d", got_n - s_got, err_code);
        check("break_nout", got_n - s_got, 2);
        entry_at(s_got, e);
        check("break_entry0", {22'd0, e}, 32'h001);
        entry_at(s_got + 1, e);
        check("break_entry1", {22'd0, e}, 32'h302);
        check("break_err", n_err - s_err, 1);
        check("break_code", {29'd0, err_code}, 32'd4);

        // Reset in the middle of a frame with bytes queued
        m_ready = 1'b0;
        send_byte(8'h7E);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("prereset_valid", {31'd0, m_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midreset_valid", {31'd0, m_valid}, 32'd0);
        check("midreset_code", {29'd0, err_code}, 32'd0);
        wait_cycles(2);
        resetn = 1'b1;
        m_ready = 1'b1;
        wait_cycles(1);
        s_got = got_n; s_good = n_good;
        for (int i = 0; i < vecs[0].nb; i++) send_byte(vecs[0].b[63-8*i -: 8]);
        wait_cycles(8);
        $display("after reset: %0d out, good=%0d", got_n - s_got, n_good - s_good);
        check("postreset_nout", got_n - s_got, 3);
        entry_at(s_got + 2, e);
        check("postreset_last", {22'd0, e}, 32'h133);
        check("postreset_good", n_good - s_good, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
